// File: rtl/led_step_gen.sv
// led_step_gen: rate-selectable step enable, debounced run/pause, direction and position for the LED shifter
module led_step_gen #(
  parameter int CNT_W     = 26,
  parameter int DIV0      = 50000000,
  parameter int DIV1      = 25000000,
  parameter int DIV2      = 12500000,
  parameter int DIV3      = 6250000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       btn,
  input  logic [1:0] spd,
  input  logic       dir_i,
  output logic       step_o,
  output logic       dir_o,
  output logic       run_o,
  output logic [2:0] pos_o
);
  localparam int DW = $clog2(DB_CYCLES);
  typedef enum logic {STABLE, CHECK} db_t;
  db_t st, st_n;
  logic s1, s2, db, db_n, db_d, rel;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [1:0] spd_r;
  logic [CNT_W-1:0] cnt, cnt_n, div_m1;
  logic chg, tc, step_n;
  // acceptance fires on the edge where the counter would reach DB_CYCLES-1
  always_comb begin
    st_n   = st;
    dcnt_n = dcnt;
    db_n   = db;
    if (st == STABLE) begin
      if (s2 != db) begin
        st_n   = CHECK;
        dcnt_n = '0;
      end
    end else if (s2 == db) begin
      st_n   = STABLE;
      dcnt_n = '0;
    end else if (dcnt == DW'(DB_CYCLES - 2)) begin
      db_n   = s2;
      st_n   = STABLE;
      dcnt_n = '0;
    end else
      dcnt_n = dcnt + DW'(1);
  end
  always_comb begin
    div_m1 = spd_r == 2'd0 ? CNT_W'(DIV0 - 1) :
             spd_r == 2'd1 ? CNT_W'(DIV1 - 1) :
             spd_r == 2'd2 ? CNT_W'(DIV2 - 1) : CNT_W'(DIV3 - 1);
    chg    = spd != spd_r;
    tc     = cnt == div_m1;
    step_n = run_o & ~chg & tc;
    cnt_n  = chg ? '0 : !run_o ? cnt : tc ? '0 : cnt + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rs) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      st     <= STABLE;
      dcnt   <= '0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      rel    <= 1'b1;
      run_o  <= 1'b1;
      spd_r  <= 2'd0;
      cnt    <= '0;
      step_o <= 1'b0;
      dir_o  <= 1'b0;
      pos_o  <= 3'd0;
    end else begin
      s1     <= btn;
      s2     <= s1;
      st     <= st_n;
      dcnt   <= dcnt_n;
      db     <= db_n;
      db_d   <= db;
      rel    <= 1'b0;
      run_o  <= run_o ^ (db & ~db_d);
      spd_r  <= spd;
      cnt    <= cnt_n;
      step_o <= step_n;
      if (rel | step_o) dir_o <= dir_i;
      if (step_n) pos_o <= dir_o ? pos_o - 3'd1 : pos_o + 3'd1;
    end
  end
endmodule
